// File: rtl/dsp_pkg.sv
// Shared definitions for the portable DSP multiply-accumulate processing element.
package dsp_pkg;

    typedef enum logic [2:0] {
        OP_M       = 3'd0,
        OP_MC      = 3'd1,
        OP_MP      = 3'd2,
        OP_MPSH    = 3'd3,
        OP_MPCIN   = 3'd4,
        OP_MPCINSH = 3'd5,
        OP_C       = 3'd6,
        OP_HOLD    = 3'd7
    } dsp_op_t;

    // Number of cycles from presenting a beat to seeing its result on P_o.
    function automatic int dsp_lat(input int abreg, input int mreg);
        return abreg + mreg + 1;
    endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// Resettable shift register used for the operand and product pipeline stages.
// A depth of zero collapses to a plain wire.
module dsp_delay_line
    import dsp_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [W-1:0] stage [DEPTH];

            // Shift the word one stage per clock; reset empties the whole line.
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// Parametrised unsigned multiply-accumulate processing element with valid
// tracking, shift-aligned accumulation and a cascade path for chaining.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int AW    = 17,
    parameter int BW    = 17,
    parameter int CW    = 34,
    parameter int PW    = 48,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1,
    parameter int SHIFT = 17
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          valid_i,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] A_i,
    input  logic [BW-1:0] B_i,
    input  logic          CREG_en_i,
    input  logic [CW-1:0] C_i,
    input  logic [PW-1:0] PCIN_i,
    output logic [PW-1:0] P_o,
    output logic [PW-1:0] PCOUT_o,
    output logic          valid_o
);

    localparam int MW  = AW + BW;
    localparam int ABW = MW + 4;
    localparam int MSW = MW + 4;

    generate
        if (ABREG < 0 || ABREG > 2) begin : g_bad_abreg
            $fatal(1, "dsp_mac_pipe: ABREG must be 0..2");
        end
        if (MREG < 0 || MREG > 1) begin : g_bad_mreg
            $fatal(1, "dsp_mac_pipe: MREG must be 0..1");
        end
        if (PW < AW + BW) begin : g_bad_pw
            $fatal(1, "dsp_mac_pipe: PW must be at least AW+BW");
        end
        if (CW > PW) begin : g_bad_cw
            $fatal(1, "dsp_mac_pipe: CW must not exceed PW");
        end
    endgenerate

    logic [ABW-1:0] ab_d;
    logic [ABW-1:0] ab_q;
    logic           ab_valid;
    logic [2:0]     ab_op;
    logic [AW-1:0]  ab_a;
    logic [BW-1:0]  ab_b;
    logic [MW-1:0]  m_raw;
    logic [MSW-1:0] m_d;
    logic [MSW-1:0] m_q;
    logic           p_valid;
    dsp_op_t        p_op;
    logic [MW-1:0]  p_m;
    logic [CW-1:0]  c_sel;
    logic [PW-1:0]  m_ext;
    logic [PW-1:0]  c_ext;
    logic [PW-1:0]  p_next;
    logic [PW-1:0]  p_q;
    logic           valid_q;

    // Operands, op and valid travel together through the input stages.
    assign ab_d = {valid_i, op_i, A_i, B_i};

    dsp_delay_line #(.W(ABW), .DEPTH(ABREG)) u_ab_stages (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d       (ab_d),
        .q       (ab_q)
    );

    assign ab_valid = ab_q[MW+3];
    assign ab_op    = ab_q[MW+2:MW];
    assign ab_a     = ab_q[MW-1:BW];
    assign ab_b     = ab_q[BW-1:0];

    assign m_raw = MW'(ab_a) * MW'(ab_b);
    assign m_d   = {ab_valid, ab_op, m_raw};

    dsp_delay_line #(.W(MSW), .DEPTH(MREG)) u_m_stages (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d       (m_d),
        .q       (m_q)
    );

    assign p_valid = m_q[MW+3];
    assign p_op    = dsp_op_t'(m_q[MW+2:MW]);
    assign p_m     = m_q[MW-1:0];

    generate
        if (CREG != 0) begin : g_creg
            logic [CW-1:0] c_reg;

            // Capture C only when enabled; the adder sees the value held before the edge.
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    c_reg <= '0;
                end else if (CREG_en_i) begin
                    c_reg <= C_i;
                end
            end

            assign c_sel = c_reg;
        end else begin : g_no_creg
            assign c_sel = C_i;
        end
    endgenerate

    assign m_ext = PW'(p_m);
    assign c_ext = PW'(c_sel);

    // Select the accumulator update for the beat that has reached the P stage.
    always_comb begin
        p_next = p_q;
        case (p_op)
            OP_M:       p_next = m_ext;
            OP_MC:      p_next = m_ext + c_ext;
            OP_MP:      p_next = m_ext + p_q;
            OP_MPSH:    p_next = m_ext + (p_q >> SHIFT);
            OP_MPCIN:   p_next = m_ext + PCIN_i;
            OP_MPCINSH: p_next = m_ext + (PCIN_i >> SHIFT);
            OP_C:       p_next = c_ext;
            OP_HOLD:    p_next = p_q;
            default:    p_next = p_q;
        endcase
    end

    // Only valid beats touch P, so bubbles never disturb a running accumulation.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= p_valid;
            if (p_valid) begin
                p_q <= p_next;
            end
        end
    end

    assign P_o     = p_q;
    assign PCOUT_o = p_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe across several pipeline configurations.
module tb_dsp_mac_pipe;
    import dsp_pkg::*;

    localparam int NI = 6;
    localparam int HN = 8192;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [16:0] A_i;
    logic [16:0] B_i;
    logic        CREG_en_i;
    logic [33:0] C_i;
    logic [47:0] PCIN_i;

    logic [47:0] p_o  [NI];
    logic [47:0] pc_o [NI];
    logic        v_o  [NI];

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int  lat  [NI];
    bit  hasc [NI];

    int          k = 0;
    logic        hv  [HN];
    logic [2:0]  hop [HN];
    logic [16:0] ha  [HN];
    logic [16:0] hb  [HN];
    logic [47:0] mp  [NI];
    logic        mv  [NI];
    logic [33:0] mcreg;

    always #5 clock_i = ~clock_i;

    dsp_mac_pipe u_def (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[0]), .PCOUT_o(pc_o[0]), .valid_o(v_o[0]));

    dsp_mac_pipe #(.ABREG(0), .MREG(0)) u_a0m0 (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[1]), .PCOUT_o(pc_o[1]), .valid_o(v_o[1]));

    dsp_mac_pipe #(.ABREG(0), .MREG(1)) u_a0m1 (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[2]), .PCOUT_o(pc_o[2]), .valid_o(v_o[2]));

    dsp_mac_pipe #(.ABREG(2), .MREG(0)) u_a2m0 (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[3]), .PCOUT_o(pc_o[3]), .valid_o(v_o[3]));

    dsp_mac_pipe #(.ABREG(2), .MREG(1)) u_a2m1 (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[4]), .PCOUT_o(pc_o[4]), .valid_o(v_o[4]));

    dsp_mac_pipe #(.CREG(0)) u_noc (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
        .A_i(A_i), .B_i(B_i), .CREG_en_i(CREG_en_i), .C_i(C_i), .PCIN_i(PCIN_i),
        .P_o(p_o[5]), .PCOUT_o(pc_o[5]), .valid_o(v_o[5]));

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic result of one beat, straight from the operation table.
    function automatic logic [47:0] alu(input logic [2:0] op, input logic [47:0] m,
                                        input logic [47:0] p, input logic [47:0] c,
                                        input logic [47:0] pcin);
        case (op)
            3'd0:    return m;
            3'd1:    return m + c;
            3'd2:    return m + p;
            3'd3:    return m + (p >> 17);
            3'd4:    return m + pcin;
            3'd5:    return m + (pcin >> 17);
            3'd6:    return c;
            default: return p;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < k; i++) hv[i] = 1'b0;
        for (int j = 0; j < NI; j++) begin
            mp[j] = '0;
            mv[j] = 1'b0;
        end
        mcreg = '0;
    endtask

    // Record the beat seen at this edge and retire the beat each configuration finishes now.
    task automatic model_edge();
        int          src;
        logic [47:0] m;
        logic [47:0] c;
        if (k >= HN) begin
            $display("[TB] FAIL history overflow observed=%0d expected<%0d", k, HN);
            $fatal(1, "[TB] history overflow");
        end
        if (reset_i) begin
            hv[k] = 1'b0;
            for (int j = 0; j < NI; j++) mv[j] = 1'b0;
        end else begin
            hv[k]  = valid_i;
            hop[k] = op_i;
            ha[k]  = A_i;
            hb[k]  = B_i;
            for (int j = 0; j < NI; j++) begin
                src = k - lat[j] + 1;
                if (src >= 0 && hv[src]) begin
                    m = 48'(ha[src]) * 48'(hb[src]);
                    c = hasc[j] ? 48'(mcreg) : 48'(C_i);
                    mp[j] = alu(hop[src], m, mp[j], c, PCIN_i);
                    mv[j] = 1'b1;
                end else begin
                    mv[j] = 1'b0;
                end
            end
            if (CREG_en_i) mcreg = C_i;
        end
        k++;
    endtask

    task automatic compare_all();
        for (int j = 0; j < NI; j++) begin
            check($sformatf("model_p%0d", j), p_o[j], mp[j]);
            check($sformatf("model_pcout%0d", j), pc_o[j], mp[j]);
            check($sformatf("model_valid%0d", j), 48'(v_o[j]), 48'(mv[j]));
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        model_edge();
        #1;
        compare_all();
        if (v_o[0] === 1'b1) pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [16:0] a, input logic [16:0] b);
        op_i    = op;
        A_i     = a;
        B_i     = b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [47:0] exp_creg, input logic [47:0] exp_noc);
        for (int j = 0; j < NI; j++) begin
            check($sformatf("%s_p%0d", tag, j), p_o[j], hasc[j] ? exp_creg : exp_noc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        lat[0] = dsp_lat(1, 1); hasc[0] = 1'b1;
        lat[1] = dsp_lat(0, 0); hasc[1] = 1'b1;
        lat[2] = dsp_lat(0, 1); hasc[2] = 1'b1;
        lat[3] = dsp_lat(2, 0); hasc[3] = 1'b1;
        lat[4] = dsp_lat(2, 1); hasc[4] = 1'b1;
        lat[5] = dsp_lat(1, 1); hasc[5] = 1'b0;
        for (int i = 0; i < HN; i++) hv[i] = 1'b0;
        for (int j = 0; j < NI; j++) begin
            mp[j] = '0;
            mv[j] = 1'b0;
        end
        mcreg     = '0;
        reset_i   = 1'b1;
        valid_i   = 1'b0;
        op_i      = 3'd0;
        A_i       = '0;
        B_i       = '0;
        CREG_en_i = 1'b0;
        C_i       = '0;
        PCIN_i    = '0;

        $display("[TB] reset");
        idle(2);
        reset_i = 1'b0;
        idle(1);
        for (int j = 0; j < NI; j++) begin
            check($sformatf("reset_p%0d", j), p_o[j], 48'd0);
            check($sformatf("reset_v%0d", j), 48'(v_o[j]), 48'd0);
        end

        $display("[TB] single beat latency");
        applyStimulus(3'd0, 17'd3, 17'd5);
        check("lat_edge0_v", 48'(v_o[0]), 48'd0);
        check("lat_a0m0_p", p_o[1], 48'd15);
        tick();
        check("lat_edge1_v", 48'(v_o[0]), 48'd0);
        tick();
        check("lat_edge2_v", 48'(v_o[0]), 48'd1);
        check("lat_edge2_p", p_o[0], 48'd15);
        tick();
        check("lat_edge3_v", 48'(v_o[0]), 48'd0);
        check("lat_edge3_p", p_o[0], 48'd15);
        idle(2);

        $display("[TB] max operands");
        applyStimulus(3'd0, 17'h1FFFF, 17'h1FFFF);
        idle(4);
        checkOutput("max_m", 48'h3_FFFC_0001, 48'h3_FFFC_0001);
        applyStimulus(3'd2, 17'h1FFFF, 17'h1FFFF);
        idle(4);
        checkOutput("max_mp", 48'h7_FFF8_0002, 48'h7_FFF8_0002);

        $display("[TB] accumulate with bubbles");
        C_i = '0;
        CREG_en_i = 1'b1;
        idle(1);
        pulses = 0;
        applyStimulus(3'd6, 17'd0, 17'd0);
        idle(4);
        CREG_en_i = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            applyStimulus(3'd2, 17'(a), 17'd2);
            idle(1);
        end
        idle(4);
        checkOutput("acc", 48'd20, 48'd20);
        check("acc_pulses", 48'(pulses), 48'd5);

        $display("[TB] shift accumulate");
        C_i = 34'h20000;
        CREG_en_i = 1'b1;
        idle(1);
        applyStimulus(3'd6, 17'd0, 17'd0);
        idle(4);
        CREG_en_i = 1'b0;
        checkOutput("load_c", 48'h20000, 48'h20000);
        applyStimulus(3'd3, 17'd1, 17'd1);
        idle(4);
        checkOutput("mpsh", 48'd2, 48'd2);
        PCIN_i = 48'h3_0000_0000;
        applyStimulus(3'd5, 17'd0, 17'd0);
        idle(4);
        checkOutput("mpcinsh", 48'h18000, 48'h18000);
        PCIN_i = '0;

        $display("[TB] C enable");
        C_i = 34'd7;
        CREG_en_i = 1'b1;
        idle(1);
        CREG_en_i = 1'b0;
        C_i = 34'd9;
        applyStimulus(3'd1, 17'd1, 17'd1);
        idle(4);
        checkOutput("cen", 48'd8, 48'd10);

        $display("[TB] reset mid-stream");
        applyStimulus(3'd0, 17'd3, 17'd5);
        applyStimulus(3'd2, 17'd3, 17'd5);
        reset_i = 1'b1;
        #1;
        model_reset();
        for (int j = 0; j < NI; j++) begin
            check($sformatf("async_p%0d", j), p_o[j], 48'd0);
            check($sformatf("async_v%0d", j), 48'(v_o[j]), 48'd0);
        end
        idle(2);
        reset_i = 1'b0;
        idle(5);
        checkOutput("no_stale", 48'd0, 48'd0);
        applyStimulus(3'd0, 17'd3, 17'd5);
        idle(4);
        checkOutput("post_reset", 48'd15, 48'd15);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            valid_i   = 1'($urandom_range(0, 1));
            op_i      = 3'($urandom_range(0, 7));
            A_i       = 17'($urandom);
            B_i       = 17'($urandom);
            CREG_en_i = 1'($urandom_range(0, 1));
            C_i       = 34'({$urandom, $urandom});
            PCIN_i    = 48'({$urandom, $urandom});
            tick();
        end
        valid_i = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
